// File: rtl/noc_pkg.sv
// Shared NoC definitions used by the network interface and the router.
// Flit layout for a head flit: [7:6] type, [5:3] dst_x, [2:0] dst_y.
// Body flits carry raw payload bytes and have no type field.
package noc_pkg;

  localparam int FLIT_W  = 8;
  localparam int COORD_W = 3;

  localparam logic [1:0] FLIT_HEAD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    BODY
  } ni_state_e;

  function automatic logic [FLIT_W-1:0] make_head(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
    return {FLIT_HEAD, x, y};
  endfunction

endpackage

// File: rtl/ni_credit_counter.sv
// Credit counter tracking free slots in the router local input FIFO.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   consume      : a flit is being sent this cycle (uses one credit)
//   credit_ret   : router freed one FIFO slot
//   count        : current registered credit count
//   has_credit   : count is non-zero
//   credit_err   : sticky; credit returned while count was already full
module ni_credit_counter #(
  parameter int CREDITS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         consume,
  input  logic                         credit_ret,
  output logic [$clog2(CREDITS+1)-1:0] count,
  output logic                         has_credit,
  output logic                         credit_err
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  assign has_credit = (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= FULL;
      credit_err <= 1'b0;
    end else begin
      unique case ({consume, credit_ret})
        2'b10: count <= count - 1'b1;
        2'b01: begin
          // An extra return at full count means the router and NI disagree;
          // keep the count pinned and flag it.
          if (count == FULL) credit_err <= 1'b1;
          else               count      <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ni_packetizer.sv
// Local-port network-interface transmitter: turns one message into a head
// flit plus PAYLOAD_BYTES body flits written into the router local FIFO,
// throttled by credits for that FIFO.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   msg_valid/msg_ready   : message handshake
//   msg_dst_x, msg_dst_y  : destination coordinates
//   msg_data              : payload, byte 0 in [7:0]
//   flit_out, flit_write  : registered flit and write strobe to router FIFO
//   credit_ret            : one-cycle credit return pulse from router
//   pkt_sent              : registered pulse alongside the last body flit
//   busy                  : state is not IDLE
//   credit_err            : sticky credit overflow flag
//
// state | meaning
// IDLE  | waiting for a message, msg_ready high
// HEAD  | message captured, sending head flit when a credit is available
// BODY  | sending payload byte idx when a credit is available
module ni_packetizer
  import noc_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 4,
  parameter int CREDITS       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       msg_valid,
  output logic                       msg_ready,
  input  logic [COORD_W-1:0]         msg_dst_x,
  input  logic [COORD_W-1:0]         msg_dst_y,
  input  logic [8*PAYLOAD_BYTES-1:0] msg_data,
  output logic [FLIT_W-1:0]          flit_out,
  output logic                       flit_write,
  input  logic                       credit_ret,
  output logic                       pkt_sent,
  output logic                       busy,
  output logic                       credit_err
);

  localparam logic [3:0] LAST = 4'(PAYLOAD_BYTES - 1);

  ni_state_e                  state;
  logic [COORD_W-1:0]         dst_x_q;
  logic [COORD_W-1:0]         dst_y_q;
  logic [8*PAYLOAD_BYTES-1:0] payload_q;
  logic [3:0]                 idx;
  logic [FLIT_W-1:0]          body_byte;
  logic                       has_credit;
  logic                       send;
  logic [$clog2(CREDITS+1)-1:0] credit_count_unused;

  assign msg_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Decision is made on the registered count, so a credit returned at edge E
  // can only be spent at edge E+1.
  assign send = has_credit && (state == HEAD || state == BODY);

  ni_credit_counter #(
    .CREDITS(CREDITS)
  ) u_credit (
    .clk       (clk),
    .rst       (rst),
    .consume   (send),
    .credit_ret(credit_ret),
    .count     (credit_count_unused),
    .has_credit(has_credit),
    .credit_err(credit_err)
  );

  always_comb begin
    body_byte = '0;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      if (idx == 4'(i)) body_byte = payload_q[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dst_x_q    <= '0;
      dst_y_q    <= '0;
      payload_q  <= '0;
      idx        <= '0;
      flit_out   <= '0;
      flit_write <= 1'b0;
      pkt_sent   <= 1'b0;
    end else begin
      flit_write <= 1'b0;
      pkt_sent   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (msg_valid) begin
            dst_x_q   <= msg_dst_x;
            dst_y_q   <= msg_dst_y;
            payload_q <= msg_data;
            state     <= HEAD;
          end
        end
        HEAD: begin
          if (has_credit) begin
            flit_out   <= make_head(dst_x_q, dst_y_q);
            flit_write <= 1'b1;
            idx        <= '0;
            state      <= BODY;
          end
        end
        BODY: begin
          if (has_credit) begin
            flit_out   <= body_byte;
            flit_write <= 1'b1;
            idx        <= idx + 4'd1;
            if (idx == LAST) begin
              pkt_sent <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ni_packetizer.sv
module tb_ni_packetizer;
  import noc_pkg::*;

  logic        clk;
  logic        rst;
  logic        msg_valid;
  logic        msg_ready;
  logic [2:0]  msg_dst_x;
  logic [2:0]  msg_dst_y;
  logic [31:0] msg_data;
  logic [7:0]  flit_out;
  logic        flit_write;
  logic        credit_ret;
  logic        pkt_sent;
  logic        busy;
  logic        credit_err;

  int total;
  int passes;

  ni_packetizer #(
    .PAYLOAD_BYTES(4),
    .CREDITS      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg_dst_x (msg_dst_x),
    .msg_dst_y (msg_dst_y),
    .msg_data  (msg_data),
    .flit_out  (flit_out),
    .flit_write(flit_write),
    .credit_ret(credit_ret),
    .pkt_sent  (pkt_sent),
    .busy      (busy),
    .credit_err(credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_flit(input string tag, input logic [7:0] data, input logic last);
    chk({tag, "_wr"}, 32'(flit_write), 32'd1);
    chk({tag, "_data"}, 32'(flit_out), 32'(data));
    chk({tag, "_pkt"}, 32'(pkt_sent), 32'(last));
  endtask

  task automatic expect_idle_line(input string tag);
    chk({tag, "_wr"}, 32'(flit_write), 32'd0);
    chk({tag, "_pkt"}, 32'(pkt_sent), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    total      = 0;
    passes     = 0;
    rst        = 1'b1;
    msg_valid  = 1'b0;
    msg_dst_x  = '0;
    msg_dst_y  = '0;
    msg_data   = '0;
    credit_ret = 1'b0;

    // Reset for two cycles
    tick();
    tick();
    rst = 1'b0;
    chk("rst_flit_write", 32'(flit_write), 32'd0);
    chk("rst_flit_out",   32'(flit_out),   32'd0);
    chk("rst_msg_ready",  32'(msg_ready),  32'd1);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_credit_err", 32'(credit_err), 32'd0);
    chk("rst_pkt_sent",   32'(pkt_sent),   32'd0);
    chk("rst_count",      32'(dut.u_credit.count), 32'd8);

    // Single packet dst (2,5), data DDCCBBAA
    msg_valid = 1'b1;
    msg_dst_x = 3'd2;
    msg_dst_y = 3'd5;
    msg_data  = 32'hDDCCBBAA;
    tick();
    msg_valid = 1'b0;
    msg_data  = 32'h12345678;  // payload must already be captured
    msg_dst_x = 3'd0;
    msg_dst_y = 3'd0;
    chk("sp_busy",      32'(busy),       32'd1);
    chk("sp_ready",     32'(msg_ready),  32'd0);
    chk("sp_nowr",      32'(flit_write), 32'd0);
    tick(); expect_flit("sp_head", 8'h95, 1'b0);
    tick(); expect_flit("sp_b0",   8'hAA, 1'b0);
    tick(); expect_flit("sp_b1",   8'hBB, 1'b0);
    tick(); expect_flit("sp_b2",   8'hCC, 1'b0);
    chk("sp_ready_mid", 32'(msg_ready), 32'd0);
    tick(); expect_flit("sp_b3",   8'hDD, 1'b1);
    chk("sp_ready_after", 32'(msg_ready), 32'd1);
    chk("sp_busy_after",  32'(busy),      32'd0);
    tick(); expect_idle_line("sp_done");
    chk("sp_count", 32'(dut.u_credit.count), 32'd3);

    // Credit exhaustion: two back-to-back messages, no returns
    do_reset();
    msg_valid = 1'b1;
    msg_dst_x = 3'd1;
    msg_dst_y = 3'd3;
    msg_data  = 32'h44332211;
    tick();
    msg_dst_x = 3'd7;
    msg_dst_y = 3'd0;
    msg_data  = 32'h88776655;
    tick(); expect_flit("ex_a_head", 8'h8B, 1'b0);
    tick(); expect_flit("ex_a_b0",   8'h11, 1'b0);
    tick(); expect_flit("ex_a_b1",   8'h22, 1'b0);
    tick(); expect_flit("ex_a_b2",   8'h33, 1'b0);
    tick(); expect_flit("ex_a_b3",   8'h44, 1'b1);
    tick();
    msg_valid = 1'b0;
    chk("ex_accept_gap", 32'(flit_write), 32'd0);
    chk("ex_b_busy",     32'(busy),       32'd1);
    tick(); expect_flit("ex_b_head", 8'hB8, 1'b0);
    tick(); expect_flit("ex_b_b0",   8'h55, 1'b0);
    tick(); expect_flit("ex_b_b1",   8'h66, 1'b0);
    tick();
    chk("ex_stall1_wr",   32'(flit_write), 32'd0);
    chk("ex_stall1_busy", 32'(busy),       32'd1);
    tick();
    chk("ex_stall2_wr",   32'(flit_write), 32'd0);
    chk("ex_count0",      32'(dut.u_credit.count), 32'd0);

    // One credit returned: exactly one flit, one cycle later
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    chk("cr_same_cycle_wr", 32'(flit_write), 32'd0);
    tick(); expect_flit("cr_b2", 8'h77, 1'b0);
    tick();
    chk("cr_stall_wr",   32'(flit_write), 32'd0);
    chk("cr_stall_busy", 32'(busy),       32'd1);

    // Simultaneous return and send at count=1
    credit_ret = 1'b1;
    tick();
    chk("sim_count1", 32'(dut.u_credit.count), 32'd1);
    chk("sim_nowr",   32'(flit_write), 32'd0);
    tick();
    credit_ret = 1'b0;
    expect_flit("sim_b3", 8'h88, 1'b1);
    chk("sim_count_held", 32'(dut.u_credit.count), 32'd1);
    msg_valid = 1'b1;
    msg_dst_x = 3'd0;
    msg_dst_y = 3'd7;
    msg_data  = 32'h0D0C0B0A;
    tick();
    msg_valid = 1'b0;
    chk("sim_c_accept", 32'(flit_write), 32'd0);
    tick(); expect_flit("sim_c_head", 8'h87, 1'b0);
    tick();
    chk("sim_c_stall_wr",   32'(flit_write), 32'd0);
    chk("sim_c_stall_busy", 32'(busy),       32'd1);

    // credit_err: return while idle at full credit
    do_reset();
    chk("ce_ready", 32'(msg_ready), 32'd1);
    chk("ce_clear", 32'(credit_err), 32'd0);
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    chk("ce_set",   32'(credit_err), 32'd1);
    chk("ce_count", 32'(dut.u_credit.count), 32'd8);
    tick();
    tick();
    chk("ce_sticky", 32'(credit_err), 32'd1);
    do_reset();
    chk("ce_cleared", 32'(credit_err), 32'd0);

    // Reset mid-packet
    msg_valid = 1'b1;
    msg_dst_x = 3'd3;
    msg_dst_y = 3'd3;
    msg_data  = 32'h4D3C2B1A;
    tick();
    msg_valid = 1'b0;
    tick(); expect_flit("rm_head", 8'h9B, 1'b0);
    tick(); expect_flit("rm_b0",   8'h1A, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_idle_line("rm_rst_edge");
    chk("rm_ready",    32'(msg_ready), 32'd1);
    chk("rm_busy",     32'(busy),      32'd0);
    chk("rm_flit_out", 32'(flit_out),  32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_idle_line("rm_quiet");
    end
    msg_valid = 1'b1;
    msg_dst_x = 3'd4;
    msg_dst_y = 3'd6;
    msg_data  = 32'hF0E0D0C0;
    tick();
    msg_valid = 1'b0;
    tick(); expect_flit("rm2_head", 8'hA6, 1'b0);
    tick(); expect_flit("rm2_b0",   8'hC0, 1'b0);
    tick(); expect_flit("rm2_b1",   8'hD0, 1'b0);
    tick(); expect_flit("rm2_b2",   8'hE0, 1'b0);
    tick(); expect_flit("rm2_b3",   8'hF0, 1'b1);
    chk("rm2_ready", 32'(msg_ready), 32'd1);
    tick(); expect_idle_line("rm2_done");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
